// File: rtl/canvas_reader.sv
// Streams a DIM x DIM canvas out as clamped pixel beats in row-major order
// over a valid/ready channel, and keeps a running sum of the accepted beats.
module canvas_reader #(
  parameter int DIM     = 28,
  parameter int PIX_W   = 16,
  parameter int MAX_VAL = 2047
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PIX_W-1:0] canvas [DIM-1:0][DIM-1:0],
  output logic [PIX_W-1:0] pix_data,
  output logic [9:0]       pix_index,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             busy,
  output logic             done,
  output logic [25:0]      pix_sum,
  output logic [1:0]       state_dbg
);

  localparam int CW   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int LAST = DIM * DIM - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    x, y, x_d, y_d, nx, ny;
  logic [PIX_W-1:0] pix_data_d;
  logic [9:0]       pix_index_d;
  logic             pix_valid_d, pix_last_d, busy_d, done_d;
  logic [25:0]      pix_sum_d;
  logic             xfer;

  function automatic logic [PIX_W-1:0] clamp(input logic [PIX_W-1:0] v);
    return (v > PIX_W'(MAX_VAL)) ? PIX_W'(MAX_VAL) : v;
  endfunction

  // A beat moves when pix_valid and pix_ready are both high at a rising edge;
  // while valid is high and ready low, every beat field stays frozen.
  assign xfer      = pix_valid && pix_ready;
  assign state_dbg = state;

  always_comb begin
    if (x == CW'(DIM - 1)) begin
      nx = '0;
      ny = y + CW'(1);
    end else begin
      nx = x + CW'(1);
      ny = y;
    end
  end

  always_comb begin
    state_d     = state;
    x_d         = x;
    y_d         = y;
    pix_data_d  = pix_data;
    pix_index_d = pix_index;
    pix_valid_d = pix_valid;
    pix_last_d  = pix_last;
    busy_d      = busy;
    done_d      = 1'b0;
    pix_sum_d   = pix_sum;
    case (state)
      IDLE: begin
        if (Start) begin
          state_d     = STREAM;
          x_d         = '0;
          y_d         = '0;
          pix_data_d  = clamp(canvas[0][0]);
          pix_index_d = '0;
          pix_valid_d = 1'b1;
          pix_last_d  = (LAST == 0);
          busy_d      = 1'b1;
          pix_sum_d   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          pix_sum_d = pix_sum + 26'(pix_data);
          if (pix_last) begin
            state_d     = DONE;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            // Canvas is sampled only here, so a presented beat never changes.
            x_d         = nx;
            y_d         = ny;
            pix_data_d  = clamp(canvas[nx][ny]);
            pix_index_d = pix_index + 10'd1;
            pix_last_d  = (pix_index + 10'd1) == 10'(LAST);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      pix_data  <= '0;
      pix_index <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_sum   <= '0;
    end else begin
      state     <= state_d;
      x         <= x_d;
      y         <= y_d;
      pix_data  <= pix_data_d;
      pix_index <= pix_index_d;
      pix_valid <= pix_valid_d;
      pix_last  <= pix_last_d;
      busy      <= busy_d;
      done      <= done_d;
      pix_sum   <= pix_sum_d;
    end
  end

endmodule

// File: doc/canvas_reader.md
CANVAS_READER -- requirements
Module: canvas_reader

Interface
REQ-001 Parameter DIM, default 28, canvas side length in cells.
REQ-002 Parameter PIX_W, default 16, width of a canvas cell and of pix_data.
REQ-003 Parameter MAX_VAL, default 2047, clamp ceiling applied to streamed pixels.
REQ-004 Clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  request to stream one full frame; sampled only in IDLE.
REQ-007 canvas  input  [PIX_W-1:0] x [DIM-1:0][DIM-1:0]  cell array indexed canvas[X][Y].
REQ-008 pix_data  output  PIX_W  current pixel value, clamped to MAX_VAL.
REQ-009 pix_index  output  10  linear index of current pixel, Y*DIM+X.
REQ-010 pix_valid  output  1  pix_data/pix_index/pix_last hold a valid beat.
REQ-011 pix_ready  input  1  consumer accepts beat when high together with pix_valid.
REQ-012 pix_last  output  1  current beat is index DIM*DIM-1.
REQ-013 busy  output  1  high in STREAM and DONE states.
REQ-014 done  output  1  single-cycle pulse after final beat accepted.
REQ-015 pix_sum  output  26  running sum of clamped values of accepted beats.

Function
REQ-016 FSM states: IDLE, STREAM, DONE; every output registered.
REQ-017 IDLE + Start=1: next cycle STREAM, X=0, Y=0, pix_valid=1, pix_index=0, pix_data=clamp(canvas[0][0]), pix_sum=0.
REQ-018 Start outside IDLE: ignored, no effect on state, counters or outputs.
REQ-019 Scan order row-major: X increments 0..DIM-1, at X=DIM-1 X wraps to 0 and Y increments.
REQ-020 Handshake: beat transfers on a cycle with pix_valid=1 and pix_ready=1.
REQ-021 pix_valid=1, pix_ready=0: pix_data, pix_index, pix_last, X, Y held stable; no canvas resample.
REQ-022 Transfer, non-last beat: next cycle presents following pixel, pix_valid stays 1; throughput one beat per cycle with pix_ready held high.
REQ-023 pix_data sampled from canvas in the cycle the beat is loaded; later canvas changes do not alter a presented beat.
REQ-024 Clamp: pix_data = canvas cell if cell <= MAX_VAL, else MAX_VAL.
REQ-025 On each transfer, pix_sum += transferred pix_data; 26-bit width, no overflow possible for DIM=28, PIX_W=16.
REQ-026 pix_last=1 exactly when pix_index = DIM*DIM-1 and pix_valid=1.
REQ-027 Transfer of last beat: next cycle DONE, pix_valid=0, pix_last=0, done=1, pix_sum final.
REQ-028 DONE lasts one cycle, then IDLE; done=0 in all other states.
REQ-029 pix_sum holds final value in IDLE until next accepted Start.
REQ-030 pix_valid never deasserts before its beat transfers.

Reset
REQ-031 Reset=1 at a rising edge, any state including mid-STREAM: next state IDLE, X=Y=0.
REQ-032 Reset values: pix_data=0, pix_index=0, pix_valid=0, pix_last=0, busy=0, done=0, pix_sum=0.
REQ-033 Reset has priority over Start and handshake in the same cycle.

Verification
REQ-034 Canvas all cells 500, Start pulse, pix_ready=1 -> 784 beats on consecutive cycles, indices 0..783, pix_last only on 783, done one cycle after, pix_sum=392000.
REQ-035 canvas[X][Y]=Y*28+X, pix_ready random -> beats in order, each value equals its index, data held stable during stalls.
REQ-036 Canvas cell canvas[3][0]=4000, others 0 -> beat index 3 reads 2047, pix_sum=2047.
REQ-037 Start pulsed again at beat 100 -> ignored; stream completes 784 beats, one done pulse.
REQ-038 Reset asserted at beat 400 with pix_ready=1 -> next cycle pix_valid=0, busy=0, pix_sum=0; new Start restarts at index 0.
